// File: rtl/inject_arbiter.sv
// ---------------------------------------------------------------------------
// inject_arbiter
//
// Merges two flit injectors (source 0 = mapper, source 1 = application) onto
// a single output port. A whole packet is forwarded from one source before the
// port can be handed to the other one; ties are broken round-robin.
//
// Packet format: header flit, size flit N, then exactly N payload flits.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous reset, active low
//   src0_rx_i      source 0 presents a flit
//   src0_credit_o  source 0 flit accepted this cycle
//   src0_data_i    source 0 flit
//   src1_rx_i      source 1 presents a flit
//   src1_credit_o  source 1 flit accepted this cycle
//   src1_data_i    source 1 flit
//   tx_o           merged port presents a flit
//   credit_i       downstream accepts a flit this cycle
//   data_o         merged flit
//   grant_o        source owning the port (meaningful while busy_o=1)
//   busy_o         a packet is in progress
// ---------------------------------------------------------------------------
module inject_arbiter #(
  parameter int FLIT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 src0_rx_i,
  output logic                 src0_credit_o,
  input  logic [FLIT_SIZE-1:0] src0_data_i,
  input  logic                 src1_rx_i,
  output logic                 src1_credit_o,
  input  logic [FLIT_SIZE-1:0] src1_data_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 grant_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    SIZE,
    PAYLOAD
  } state_t;

  localparam logic [FLIT_SIZE-1:0] COUNT_ONE = {{(FLIT_SIZE-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 grant_q, grant_d;
  // Source that owned the most recently completed packet; the other one wins a tie.
  logic                 rr_q, rr_d;
  logic [FLIT_SIZE-1:0] count_q, count_d;

  logic                 sel_rx;
  logic [FLIT_SIZE-1:0] sel_data;
  logic                 xfer;

  // Granted source mux, used by every non-idle state.
  assign sel_rx   = grant_q ? src1_rx_i : src0_rx_i;
  assign sel_data = grant_q ? src1_data_i : src0_data_i;
  assign xfer     = sel_rx & credit_i;
  assign grant_o  = grant_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      rr_q    <= 1'b1;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    count_d       = count_q;
    tx_o          = 1'b0;
    data_o        = '0;
    src0_credit_o = 1'b0;
    src1_credit_o = 1'b0;
    busy_o        = 1'b0;

    if (state_q == IDLE) begin
      // The idle cycle only arbitrates; no flit is consumed here.
      if (src0_rx_i && src1_rx_i) begin
        grant_d = ~rr_q;
        state_d = HEADER;
      end else if (src0_rx_i) begin
        grant_d = 1'b0;
        state_d = HEADER;
      end else if (src1_rx_i) begin
        grant_d = 1'b1;
        state_d = HEADER;
      end
    end else begin
      // Zero-latency passthrough of the granted source for the whole packet.
      tx_o          = sel_rx;
      data_o        = sel_data;
      src0_credit_o = ~grant_q & credit_i;
      src1_credit_o = grant_q & credit_i;
      busy_o        = 1'b1;

      if (xfer) begin
        case (state_q)
          HEADER: begin
            state_d = SIZE;
          end
          SIZE: begin
            count_d = sel_data;
            if (sel_data == '0) begin
              state_d = IDLE;
              rr_d    = grant_q;
            end else begin
              state_d = PAYLOAD;
            end
          end
          PAYLOAD: begin
            count_d = count_q - COUNT_ONE;
            if (count_q == COUNT_ONE) begin
              state_d = IDLE;
              rr_d    = grant_q;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inject_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inject_arbiter
//
// Two packet sources feed queued flits into the arbiter. A packet-level model
// (owner, flit index within the packet, announced size) predicts every output
// each cycle; directed scenarios pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_inject_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src0_rx = 1'b0, src1_rx = 1'b0, credit = 1'b0;
  logic [31:0] src0_data = '0, src1_data = '0;
  logic        src0_credit, src1_credit, tx, grant, busy;
  logic [31:0] data_out;

  inject_arbiter #(.FLIT_SIZE(32)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .src0_rx_i    (src0_rx),
    .src0_credit_o(src0_credit),
    .src0_data_i  (src0_data),
    .src1_rx_i    (src1_rx),
    .src1_credit_o(src1_credit),
    .src1_data_i  (src1_data),
    .tx_o         (tx),
    .credit_i     (credit),
    .data_o       (data_out),
    .grant_o      (grant),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          src;
    logic [31:0] data;
    int          cyc;
  } xfer_t;

  logic [31:0] q0[$], q1[$], sent0[$], sent1[$];
  xfer_t       out_log[$];
  bit          cr_pat[$], drop0[$];
  bit          rnd_rx = 0, rnd_cr = 0;

  // Packet-level reference state.
  bit          m_busy = 0, m_owner = 0, m_last = 1;
  longint      m_idx = 0, m_size = 0;

  int          cyc = 0, n_checks = 0, n_fail = 0;
  int          busy_cnt = 0, acc0 = 0, acc1 = 0;

  task automatic check1(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic enqPkt(bit s, logic [31:0] hdr, logic [31:0] size, logic [31:0] base, int npay);
    logic [31:0] f;
    for (int i = 0; i < npay + 2; i++) begin
      f = (i == 0) ? hdr : (i == 1) ? size : base + 32'(i - 2);
      if (s) begin
        q1.push_back(f);
        sent1.push_back(f);
      end else begin
        q0.push_back(f);
        sent0.push_back(f);
      end
    end
  endtask

  // Drive the sources and downstream credit just after the rising edge.
  task automatic applyStimulus();
    bit r0, r1;
    r0 = (q0.size() > 0) && (!rnd_rx || $urandom_range(0, 3) != 0);
    r1 = (q1.size() > 0) && (!rnd_rx || $urandom_range(0, 3) != 0);
    if (drop0.size() > 0) begin
      if (drop0.pop_front()) r0 = 0;
    end
    src0_rx   = r0;
    src1_rx   = r1;
    src0_data = r0 ? q0[0] : $urandom;
    src1_data = r1 ? q1[0] : $urandom;
    if (cr_pat.size() > 0) credit = cr_pat.pop_front();
    else credit = rnd_cr ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  // Compare every output against the packet-level model (falling edge).
  task automatic checkOutput();
    logic        e_tx, e_c0, e_c1;
    logic [31:0] e_data;
    if (m_busy) begin
      e_tx   = m_owner ? src1_rx : src0_rx;
      e_data = m_owner ? src1_data : src0_data;
      e_c0   = !m_owner && credit;
      e_c1   = m_owner && credit;
      check1("grant", grant, m_owner);
    end else begin
      e_tx = 0; e_data = '0; e_c0 = 0; e_c1 = 0;
    end
    check1("tx", tx, e_tx);
    check1("data", data_out, e_data);
    check1("src0_credit", src0_credit, e_c0);
    check1("src1_credit", src1_credit, e_c1);
    check1("busy", busy, m_busy);
    busy_cnt += int'(busy);
    acc0 += int'(src0_rx && src0_credit);
    acc1 += int'(src1_rx && src1_credit);
  endtask

  // Advance the model with the inputs that were stable across the rising edge.
  task automatic modelStep();
    logic [31:0] flit;
    bit          rx;
    cyc++;
    if (!m_busy) begin
      if (src0_rx || src1_rx) begin
        m_owner = (src0_rx && src1_rx) ? ~m_last : src1_rx;
        m_busy  = 1;
        m_idx   = 0;
      end
    end else begin
      rx = m_owner ? src1_rx : src0_rx;
      if (rx && credit) begin
        flit = m_owner ? src1_data : src0_data;
        if (m_owner) void'(q1.pop_front());
        else void'(q0.pop_front());
        out_log.push_back('{m_owner, flit, cyc});
        if (m_idx == 1) m_size = longint'(flit);
        m_idx++;
        if (m_idx >= 2 && m_idx == m_size + 2) begin
          m_busy = 0;
          m_last = m_owner;
        end
      end
    end
  endtask

  task automatic runCycle();
    applyStimulus();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic drain(int budget, string name);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_busy) && k < budget) begin
      runCycle();
      k++;
    end
    check1({name, "_drained"}, (q0.size() > 0 || q1.size() > 0 || m_busy), 0);
  endtask

  // Asserts reset away from the clock edge and checks the outputs at once.
  task automatic resetDut();
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check1("reset_tx", tx, 0);
    check1("reset_data", data_out, 0);
    check1("reset_src0_credit", src0_credit, 0);
    check1("reset_src1_credit", src1_credit, 0);
    check1("reset_busy", busy, 0);
    check1("reset_grant", grant, 0);
    src0_rx = 0; src1_rx = 0; credit = 0; src0_data = '0; src1_data = '0;
    q0.delete(); q1.delete(); sent0.delete(); sent1.delete();
    out_log.delete(); cr_pat.delete(); drop0.delete();
    m_busy = 0; m_last = 1; m_owner = 0; m_idx = 0; m_size = 0;
    busy_cnt = 0; acc0 = 0; acc1 = 0; rnd_rx = 0; rnd_cr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          start, k, i0, i1;
    logic [31:0] exp033[4] = '{32'h0101, 32'd2, 32'hA, 32'hB};
    logic [31:0] exp034[6] = '{32'h10, 32'd1, 32'h11, 32'h20, 32'd1, 32'h21};
    bit          src034[6] = '{0, 0, 0, 1, 1, 1};
    int          cyc034[6] = '{2, 3, 4, 6, 7, 8};

    // Single source, back-to-back transfers after one idle cycle.
    resetDut();
    enqPkt(0, 32'h0101, 32'd2, 32'hA, 2);
    start = cyc;
    drain(50, "s033");
    runCycle();
    check1("s033_len", out_log.size(), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      check1("s033_data", out_log[i].data, exp033[i]);
      check1("s033_src", out_log[i].src, 0);
      check1("s033_cyc", out_log[i].cyc, start + 2 + i);
    end
    check1("s033_busy_cycles", busy_cnt, 4);
    check1("s033_src1_acc", acc1, 0);

    // Tie from reset: source 0 first, one idle cycle, then source 1.
    resetDut();
    enqPkt(0, 32'h10, 32'd1, 32'h11, 1);
    enqPkt(1, 32'h20, 32'd1, 32'h21, 1);
    start = cyc;
    drain(50, "s034a");
    check1("s034_len", out_log.size(), 6);
    for (int i = 0; i < 6 && i < out_log.size(); i++) begin
      check1("s034_data", out_log[i].data, exp034[i]);
      check1("s034_src", out_log[i].src, src034[i]);
      check1("s034_cyc", out_log[i].cyc, start + cyc034[i]);
    end
    enqPkt(0, 32'h12, 32'd1, 32'h13, 1);
    enqPkt(1, 32'h22, 32'd1, 32'h23, 1);
    drain(50, "s034b");
    check1("s034_len2", out_log.size(), 12);
    if (out_log.size() == 12) begin
      check1("s034_tie2_first", out_log[6].src, 0);
      check1("s034_tie2_second", out_log[9].src, 1);
    end

    // Zero-size packet: header and size only.
    resetDut();
    enqPkt(1, 32'h30, 32'd0, 32'h0, 0);
    drain(50, "s035");
    check1("s035_len", out_log.size(), 2);
    check1("s035_busy_cycles", busy_cnt, 2);
    if (out_log.size() > 0) check1("s035_hdr", out_log[0].data, 32'h30);

    // Credit stalls and a source bubble during source 0 payload.
    resetDut();
    enqPkt(0, 32'h40, 32'd4, 32'h41, 4);
    enqPkt(1, 32'h50, 32'd1, 32'h51, 1);
    cr_pat = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
    drop0  = '{0, 0, 0, 0, 0, 1, 0, 0};
    drain(100, "s036");
    check1("s036_src0_acc", acc0, 6);
    check1("s036_src1_acc", acc1, 3);
    check1("s036_len", out_log.size(), 9);
    for (int i = 0; i < 6 && i < out_log.size(); i++) begin
      check1("s036_src", out_log[i].src, 0);
      check1("s036_data", out_log[i].data, sent0[i]);
    end

    // Reset after two of five payload flits; new source 1 packet afterwards.
    resetDut();
    enqPkt(0, 32'h60, 32'd5, 32'h61, 5);
    k = 0;
    while (out_log.size() < 4 && k < 50) begin
      runCycle();
      k++;
    end
    check1("s037_partial", out_log.size(), 4);
    resetDut();
    enqPkt(1, 32'h70, 32'd1, 32'h71, 1);
    start = cyc;
    drain(50, "s037");
    check1("s037_len", out_log.size(), 3);
    if (out_log.size() > 0) begin
      check1("s037_src", out_log[0].src, 1);
      check1("s037_hdr", out_log[0].data, 32'h70);
      check1("s037_cyc", out_log[0].cyc, start + 2);
    end

    // Maximum size packet cut short by reset after 1000 payload flits.
    resetDut();
    rnd_cr = 1;
    enqPkt(0, 32'h80, 32'hFFFF_FFFF, 32'h1000, 1000);
    k = 0;
    while (q0.size() > 0 && k < 6000) begin
      runCycle();
      k++;
    end
    repeat (5) runCycle();
    check1("s038_len", out_log.size(), 1002);
    @(negedge clk);
    check1("s038_still_busy", busy, 1);
    resetDut();

    // Randomized mix of packets from both sources.
    rnd_rx = 1;
    rnd_cr = 1;
    for (int p = 0; p < 40; p++) begin
      k = $urandom_range(0, 6);
      enqPkt(1'($urandom_range(0, 1)), $urandom, 32'(k), $urandom, k);
    end
    drain(20000, "rand");
    check1("rand_len", out_log.size(), sent0.size() + sent1.size());
    i0 = 0;
    i1 = 0;
    foreach (out_log[i]) begin
      if (out_log[i].src == 0) begin
        if (i0 < sent0.size()) check1("rand_stream0", out_log[i].data, sent0[i0]);
        i0++;
      end else begin
        if (i1 < sent1.size()) check1("rand_stream1", out_log[i].data, sent1[i1]);
        i1++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
